tetris6x6_matrix_scan: RTL and testbench
========================================

Name: tetris6x6_matrix_scan

Overview:
Display-side consumer of the 6x6 game's row0..row5 bus. It snapshots all six rows into a shadow frame buffer once per frame, so the game can update rows mid-frame without tearing. It then scans the frame one row at a time onto a row-multiplexed 6x6 LED matrix, with a programmable dwell per row and blanking between rows to suppress ghosting. It sits between the game core and the matrix pins.

Parameters:
DIV, 4, clock cycles per row slot (2..255)
BLANK, 1, leading cycles of each slot with outputs blanked (1..DIV-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
row0  in  6  live row 0 from game (bit0 = leftmost column)
row1  in  6  live row 1
row2  in  6  live row 2
row3  in  6  live row 3
row4  in  6  live row 4
row5  in  6  live row 5
en  in  1  display enable; 0 forces row_sel/col to 0
hold  in  1  1 = skip snapshot at frame boundary (freeze frame)
row_sel  out  6  one-hot active-high row driver, bit k = row k
col  out  6  column data for selected row
frame_start  out  1  one-cycle pulse, first cycle of each new frame
frame_cnt  out  8  count of snapshots taken, wraps 255->0

Behaviour:
- One clock domain. All state is asynchronously cleared when rst_n=0. Only rst_n is async.
- Reset values: shadow[0..5]=0, cur_row=0, cnt=0, frame_start=0, frame_cnt=0. row_sel=0 and col=0 because cnt=0 < BLANK.
- Prescaler: cnt counts 0..DIV-1 and wraps to 0. A slot ends when cnt==DIV-1.
- At a slot end: cur_row increments, and 5 wraps to 0.
- Frame period is 6*DIV cycles. The row order is always 0,1,2,3,4,5.
- Output decode is combinational from registered state:
  - cnt < BLANK or en=0: row_sel=0, col=0.
  - Otherwise: row_sel = 1<<cur_row, col = shadow[cur_row].
- Snapshot event: the cycle with cur_row==5 and cnt==DIV-1.
  - hold=0: shadow[k] <= row_k for all k, sampled in that cycle. frame_cnt increments.
  - hold=1: shadow unchanged, frame_cnt unchanged.
- frame_start: registered. It is 1 in the cycle after every frame boundary (cur_row 5->0), whether or not a snapshot was taken. It is never 1 before the first boundary after reset.
- Latency: a change on row_k is visible on col no earlier than the next snapshot. Worst case is 6*DIV cycles plus the slot offset of row k.
- After reset, frame 0 displays all zeros. The first real frame begins at cycle 6*DIV.
- Live rows are never shown directly. Changes between snapshots have no effect on outputs.
- en is sampled every cycle and affects only output gating. The prescaler, scan, snapshot, frame_start and frame_cnt run regardless of en.
- rst_n asserted mid-frame: outputs go to 0 immediately (async). The scan restarts at row 0, cnt 0.
- The shadow is never partially updated: all six rows load in the same cycle.
- Implementation must reject illegal parameters (BLANK<1, BLANK>=DIV, DIV<2) at elaboration.

Test Plan:
- Reset, then en=1, hold=0, DIV=4, BLANK=1, rows held constant -> cycles 0..23: row_sel=0 on every cnt=0 cycle, col=0 throughout. Cycle 23 snapshots the rows. Cycle 24: frame_start=1, frame_cnt=1, row_sel=0 (blank). Cycles 25..27: row_sel=000001, col=row0.
- Rows 0..5 = 6'h01,02,04,08,10,20 after first snapshot -> each slot's active cycles show row_sel=1<<k with col=1<<k. Diagonal repeats every 24 cycles.
- Change row3 from 0x00 to 0x3F in the middle of frame N -> col during the row3 slot stays 0x00 for frame N and becomes 0x3F in frame N+1.
- hold=1 across one boundary -> frame_start still pulses, frame_cnt does not increment, and the previous frame repeats unchanged despite new live rows.
- en=0 for a whole frame -> row_sel=0 and col=0 every cycle. frame_start/frame_cnt keep advancing. After en returns to 1, the scan resumes in phase with no skipped rows.
- rst_n pulsed low asynchronously mid row-2 slot -> outputs 0 immediately, frame_cnt=0. After release the scan restarts at row 0, and the first frame_start occurs 6*DIV cycles later.

Source files
------------

// File: rtl/tetris6x6_matrix_scan.sv
// tetris6x6_matrix_scan
// Display-side consumer of the 6x6 game row bus. All six live rows are
// copied into a shadow frame buffer once per frame, at the last cycle of
// the row-5 slot. The shadow is then scanned one row per slot onto a
// row-multiplexed LED matrix. The first BLANK cycles of every slot are
// blanked so that a row does not ghost into the next one.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   row0..row5 [5:0]   live rows from the game (bit0 = leftmost column)
//   en                 display enable; gates the outputs only
//   hold               1 = skip the snapshot at the frame boundary
//   row_sel [5:0]      one-hot active-high row driver
//   col [5:0]          column data for the selected row
//   frame_start        one-cycle pulse on the first cycle of each frame
//   frame_cnt [7:0]    number of snapshots taken, wraps 255->0
module tetris6x6_matrix_scan #(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] row0,
    input  logic [5:0] row1,
    input  logic [5:0] row2,
    input  logic [5:0] row3,
    input  logic [5:0] row4,
    input  logic [5:0] row5,
    input  logic       en,
    input  logic       hold,
    output logic [5:0] row_sel,
    output logic [5:0] col,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    generate
        if (DIV < 2 || DIV > 255 || BLANK < 1 || BLANK >= DIV) begin : g_bad_params
            $error("tetris6x6_matrix_scan: need 2 <= DIV <= 255 and 1 <= BLANK < DIV");
        end
    endgenerate

    // Guard keeps the width legal even when the check above fires.
    localparam int            CW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic [CW-1:0]   cnt;
    logic [2:0]      cur_row;
    logic [5:0][5:0] shadow;
    logic [5:0][5:0] live;
    logic            slot_end;
    logic            frame_end;
    logic            snap;

    // live[k] = row k
    assign live      = {row5, row4, row3, row2, row1, row0};
    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (cur_row == 3'd5);
    assign snap      = frame_end && !hold;

    // Prescaler and row scan: free-running, independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            cur_row <= 3'd0;
        end else if (slot_end) begin
            cnt     <= '0;
            cur_row <= (cur_row == 3'd5) ? 3'd0 : cur_row + 3'd1;
        end else begin
            cnt     <= cnt + CW'(1);
        end
    end

    // Whole-frame snapshot: all six rows load in the same cycle, so the
    // displayed frame can never mix two game states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            frame_cnt <= 8'd0;
        end else if (snap) begin
            shadow    <= live;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Pulses on every boundary, even when hold suppressed the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_start <= 1'b0;
        else        frame_start <= frame_end;
    end

    // Output decode from registered state only.
    always_comb begin
        row_sel = 6'd0;
        col     = 6'd0;
        if (en && (cnt >= CNT_BLANK)) begin
            row_sel = 6'd1 << cur_row;
            col     = shadow[cur_row];
        end
    end

endmodule

// File: tb/tb_tetris6x6_matrix_scan.sv
module tb_tetris6x6_matrix_scan;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 6 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] row0, row1, row2, row3, row4, row5;
    logic       en, hold;
    logic [5:0] row_sel, col;
    logic       frame_start;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int t = 0;      // cycles since the last reset release

    always #5 clk = ~clk;

    tetris6x6_matrix_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .rst_n(rst_n),
        .row0(row0), .row1(row1), .row2(row2),
        .row3(row3), .row4(row4), .row5(row5),
        .en(en), .hold(hold),
        .row_sel(row_sel), .col(col),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic tick_to(input int target);
        while (t < target) tick();
    endtask

    task automatic set_rows(input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2,
                            input logic [5:0] r3, input logic [5:0] r4, input logic [5:0] r5);
        row0 = r0; row1 = r1; row2 = r2; row3 = r3; row4 = r4; row5 = r5;
    endtask

    // Expected row_sel while en=1: blank on cnt<BLANK, else one-hot of the slot row.
    function automatic logic [5:0] scan_rs(input int tt);
        if ((tt % DIV) < BLANK) return 6'd0;
        return 6'd1 << ((tt / DIV) % 6);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; hold = 1'b0;
        set_rows(6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20);
        repeat (3) @(posedge clk);
        #2;
        checks++; if (row_sel !== 6'h00) begin errors++; $display("FAIL reset_row_sel got %h exp 00", row_sel); end
        checks++; if (col !== 6'h00) begin errors++; $display("FAIL reset_col got %h exp 00", col); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        t = 0;
    endtask

    // Frame 0 shows the all-zero shadow; first snapshot lands at cycle 23.
    task automatic test_first_frame();
        for (int i = 0; i < FRAME; i++) begin
            checks++; if (row_sel !== scan_rs(t)) begin errors++; $display("FAIL f0_row_sel t=%0d got %h exp %h", t, row_sel, scan_rs(t)); end
            checks++; if (col !== 6'h00) begin errors++; $display("FAIL f0_col t=%0d got %h exp 00", t, col); end
            checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL f0_frame_start t=%0d got %b exp 0", t, frame_start); end
            tick();
        end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL f1_frame_start t=%0d got %b exp 1", t, frame_start); end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL f1_frame_cnt got %0d exp 1", frame_cnt); end
        checks++; if (row_sel !== 6'h00) begin errors++; $display("FAIL f1_blank got %h exp 00", row_sel); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (row_sel !== 6'h01) begin errors++; $display("FAIL f1_row0_sel t=%0d got %h exp 01", t, row_sel); end
            checks++; if (col !== 6'h01) begin errors++; $display("FAIL f1_row0_col t=%0d got %h exp 01", t, col); end
        end
    endtask

    // Diagonal pattern: col equals row_sel in every active cycle.
    task automatic test_diagonal();
        tick();
        while (t < 2 * FRAME) begin
            checks++; if (row_sel !== scan_rs(t)) begin errors++; $display("FAIL diag_row_sel t=%0d got %h exp %h", t, row_sel, scan_rs(t)); end
            checks++; if (col !== scan_rs(t)) begin errors++; $display("FAIL diag_col t=%0d got %h exp %h", t, col, scan_rs(t)); end
            checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL diag_frame_start t=%0d got %b exp 0", t, frame_start); end
            tick();
        end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL f2_frame_start got %b exp 1", frame_start); end
        checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL f2_frame_cnt got %0d exp 2", frame_cnt); end
    endtask

    task automatic test_midframe_change();
        // t=48: clear live row3; frame 2 must still show the old 08.
        row3 = 6'h00;
        while (t < 72) begin
            if (t >= 61 && t <= 63) begin
                checks++; if (col !== 6'h08) begin errors++; $display("FAIL f2_row3_col t=%0d got %h exp 08", t, col); end
            end
            tick();
        end
        checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL f3_frame_cnt got %0d exp 3", frame_cnt); end
        tick_to(80);
        row3 = 6'h3F;           // mid frame 3, in the row-2 slot
        tick_to(85);
        for (int i = 0; i < 3; i++) begin
            checks++; if (row_sel !== 6'h08) begin errors++; $display("FAIL f3_row3_sel t=%0d got %h exp 08", t, row_sel); end
            checks++; if (col !== 6'h00) begin errors++; $display("FAIL f3_row3_col t=%0d got %h exp 00", t, col); end
            tick();
        end
        tick_to(96);
        checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL f4_frame_cnt got %0d exp 4", frame_cnt); end
        tick_to(109);
        for (int i = 0; i < 3; i++) begin
            checks++; if (row_sel !== 6'h08) begin errors++; $display("FAIL f4_row3_sel t=%0d got %h exp 08", t, row_sel); end
            checks++; if (col !== 6'h3F) begin errors++; $display("FAIL f4_row3_col t=%0d got %h exp 3f", t, col); end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [5:0] exp_col;
        tick_to(112);
        hold = 1'b1;
        set_rows(6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
        tick_to(120);
        hold = 1'b0;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL hold_frame_start got %b exp 1", frame_start); end
        checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL hold_frame_cnt got %0d exp 4", frame_cnt); end
        // Frame 5 repeats frame 4: diagonal with row3 = 3F.
        while (t < 144) begin
            exp_col = scan_rs(t);
            if (exp_col == 6'h08) exp_col = 6'h3F;
            checks++; if (row_sel !== scan_rs(t)) begin errors++; $display("FAIL hold_row_sel t=%0d got %h exp %h", t, row_sel, scan_rs(t)); end
            checks++; if (col !== exp_col) begin errors++; $display("FAIL hold_col t=%0d got %h exp %h", t, col, exp_col); end
            tick();
        end
        checks++; if (frame_cnt !== 8'd5) begin errors++; $display("FAIL post_hold_frame_cnt got %0d exp 5", frame_cnt); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL post_hold_frame_start got %b exp 1", frame_start); end
        tick();
        checks++; if (row_sel !== 6'h01) begin errors++; $display("FAIL post_hold_row_sel got %h exp 01", row_sel); end
        checks++; if (col !== 6'h3F) begin errors++; $display("FAIL post_hold_col got %h exp 3f", col); end
    endtask

    task automatic test_enable();
        tick_to(168);
        en = 1'b0;
        set_rows(6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20);
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL en0_frame_start got %b exp 1", frame_start); end
        checks++; if (frame_cnt !== 8'd6) begin errors++; $display("FAIL en0_frame_cnt got %0d exp 6", frame_cnt); end
        while (t < 192) begin
            checks++; if (row_sel !== 6'h00) begin errors++; $display("FAIL en0_row_sel t=%0d got %h exp 00", t, row_sel); end
            checks++; if (col !== 6'h00) begin errors++; $display("FAIL en0_col t=%0d got %h exp 00", t, col); end
            tick();
        end
        en = 1'b1;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL en1_frame_start got %b exp 1", frame_start); end
        checks++; if (frame_cnt !== 8'd7) begin errors++; $display("FAIL en1_frame_cnt got %0d exp 7", frame_cnt); end
        while (t < 216) begin
            checks++; if (row_sel !== scan_rs(t)) begin errors++; $display("FAIL en1_row_sel t=%0d got %h exp %h", t, row_sel, scan_rs(t)); end
            checks++; if (col !== scan_rs(t)) begin errors++; $display("FAIL en1_col t=%0d got %h exp %h", t, col, scan_rs(t)); end
            tick();
        end
        checks++; if (frame_cnt !== 8'd8) begin errors++; $display("FAIL f9_frame_cnt got %0d exp 8", frame_cnt); end
    endtask

    task automatic test_async_reset();
        tick_to(225);   // row-2 slot, cnt=1
        checks++; if (row_sel !== 6'h04) begin errors++; $display("FAIL pre_rst_row_sel got %h exp 04", row_sel); end
        checks++; if (col !== 6'h04) begin errors++; $display("FAIL pre_rst_col got %h exp 04", col); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (row_sel !== 6'h00) begin errors++; $display("FAIL async_rst_row_sel got %h exp 00", row_sel); end
        checks++; if (col !== 6'h00) begin errors++; $display("FAIL async_rst_col got %h exp 00", col); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL async_rst_frame_cnt got %0d exp 0", frame_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        t = 0;
        while (t < FRAME) begin
            checks++; if (row_sel !== scan_rs(t)) begin errors++; $display("FAIL rst_f0_row_sel t=%0d got %h exp %h", t, row_sel, scan_rs(t)); end
            checks++; if (col !== 6'h00) begin errors++; $display("FAIL rst_f0_col t=%0d got %h exp 00", t, col); end
            checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_f0_frame_start t=%0d got %b exp 0", t, frame_start); end
            tick();
        end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rst_f1_frame_start got %b exp 1", frame_start); end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL rst_f1_frame_cnt got %0d exp 1", frame_cnt); end
        tick();
        checks++; if (col !== 6'h01) begin errors++; $display("FAIL rst_f1_col got %h exp 01", col); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_diagonal();
        test_midframe_change();
        test_hold();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0d", t);
        $fatal(1, "watchdog");
    end

endmodule
